delay_line_ctrl: RTL and testbench

Address sequencer and fill-state controller for a RAM-based programmable delay line. It drives the write and read ports of an external simple-dual-port synchronous RAM so that the pair behaves as an enable-gated delay chain of runtime-selectable length. It also flags which RAM read results are valid delayed samples. It sits beside the delay-chain memory in the datapath and replaces a fixed-length shift register when the delay must change without re-synthesis.

---
 rtl/delay_line_ctrl.sv | 86 ++++++++
 tb/tb_delay_line_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/delay_line_ctrl.sv
// Address sequencer and fill-state tracker for a RAM-based programmable delay line.
// Drives a simple-dual-port RAM (1-cycle read) so it acts as an en-gated delay chain.
module delay_line_ctrl #(
  parameter int AW      = 3,
  parameter int DEF_LEN = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] cfg_len,
  input  logic          cfg_load,
  input  logic          flush,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  output logic          dout_vld,
  output logic [AW-1:0] cur_len,
  output logic [AW-1:0] fill_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] wptr;
  logic          restart;
  logic [AW-1:0] new_len;
  logic [AW-1:0] fill_inc;

  assign restart  = cfg_load | flush;
  assign fill_inc = fill_cnt + AW'(1);

  // Length that applies after a restart: cfg_load wins over flush, zero clamps to one.
  always_comb begin
    new_len = cur_len;
    if (cfg_load) begin
      new_len = (cfg_len == '0) ? AW'(1) : cfg_len;
    end
  end

  // A restart cycle never reads: the line holds no valid sample at the new length yet.
  assign ram_we    = en;
  assign ram_waddr = wptr;
  assign ram_re    = en & ~restart & (state == RUN);
  assign ram_raddr = ram_re ? (wptr - cur_len) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      cur_len  <= AW'(DEF_LEN);
      fill_cnt <= '0;
      state    <= EMPTY;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= ram_re;
      if (en) begin
        wptr <= wptr + AW'(1);
      end
      if (restart) begin
        cur_len <= new_len;
        if (en) begin
          fill_cnt <= AW'(1);
          state    <= (new_len == AW'(1)) ? RUN : FILL;
        end else begin
          fill_cnt <= '0;
          state    <= EMPTY;
        end
      end else if (en) begin
        case (state)
          RUN: begin
            state <= RUN;
          end
          default: begin
            fill_cnt <= fill_inc;
            state    <= (fill_inc == cur_len) ? RUN : FILL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed self-checking bench for delay_line_ctrl (AW=3, DEF_LEN=5).
// Inputs change at negedge; outputs are sampled 1 time unit later, mid-cycle.
module tb_delay_line_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] cfg_len;
  logic       cfg_load;
  logic       flush;
  logic       ram_we;
  logic [2:0] ram_waddr;
  logic       ram_re;
  logic [2:0] ram_raddr;
  logic       dout_vld;
  logic [2:0] cur_len;
  logic [2:0] fill_cnt;

  int checks = 0;
  int passed = 0;

  delay_line_ctrl #(.AW(3), .DEF_LEN(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_len  (cfg_len),
    .cfg_load (cfg_load),
    .flush    (flush),
    .ram_we   (ram_we),
    .ram_waddr(ram_waddr),
    .ram_re   (ram_re),
    .ram_raddr(ram_raddr),
    .dout_vld (dout_vld),
    .cur_len  (cur_len),
    .fill_cnt (fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drives one cycle of inputs, then checks combinational RAM controls for this
  // cycle together with the registered outputs produced by the previous edge.
  task automatic applyStimulus(input string tag, input logic r, input logic e,
                               input logic ld, input logic fl, input logic [2:0] len,
                               input int we, input int wa, input int re, input int ra,
                               input int vld, input int cl, input int fc);
    @(negedge clk);
    rst      = r;
    en       = e;
    cfg_load = ld;
    flush    = fl;
    cfg_len  = len;
    #1;
    checkOutput({tag, ".ram_we"},    {31'd0, ram_we},    we);
    checkOutput({tag, ".ram_waddr"}, {29'd0, ram_waddr}, wa);
    checkOutput({tag, ".ram_re"},    {31'd0, ram_re},    re);
    checkOutput({tag, ".ram_raddr"}, {29'd0, ram_raddr}, ra);
    checkOutput({tag, ".dout_vld"},  {31'd0, dout_vld},  vld);
    checkOutput({tag, ".cur_len"},   {29'd0, cur_len},   cl);
    checkOutput({tag, ".fill_cnt"},  {29'd0, fill_cnt},  fc);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0; flush = 1'b0; cfg_len = 3'd0;
    repeat (2) @(posedge clk);

    //               tag      rst en ld fl len  we wa re ra vld cl fc
    applyStimulus("reset",    0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 5, 0);
    // Basic fill and run, then wrap-around
    applyStimulus("ev0",      0, 1, 0, 0, 3'd0, 1, 0, 0, 0, 0, 5, 0);
    applyStimulus("ev1",      0, 1, 0, 0, 3'd0, 1, 1, 0, 0, 0, 5, 1);
    applyStimulus("ev2",      0, 1, 0, 0, 3'd0, 1, 2, 0, 0, 0, 5, 2);
    applyStimulus("ev3",      0, 1, 0, 0, 3'd0, 1, 3, 0, 0, 0, 5, 3);
    applyStimulus("ev4",      0, 1, 0, 0, 3'd0, 1, 4, 0, 0, 0, 5, 4);
    applyStimulus("ev5",      0, 1, 0, 0, 3'd0, 1, 5, 1, 0, 0, 5, 5);
    applyStimulus("ev6",      0, 1, 0, 0, 3'd0, 1, 6, 1, 1, 1, 5, 5);
    applyStimulus("ev7",      0, 1, 0, 0, 3'd0, 1, 7, 1, 2, 1, 5, 5);
    applyStimulus("ev8",      0, 1, 0, 0, 3'd0, 1, 0, 1, 3, 1, 5, 5);
    applyStimulus("ev9",      0, 1, 0, 0, 3'd0, 1, 1, 1, 4, 1, 5, 5);
    // Gapped enable during RUN
    applyStimulus("gap1",     0, 0, 0, 0, 3'd0, 0, 2, 0, 0, 1, 5, 5);
    applyStimulus("gap2",     0, 0, 0, 0, 3'd0, 0, 2, 0, 0, 0, 5, 5);
    applyStimulus("ev10",     0, 1, 0, 0, 3'd0, 1, 2, 1, 5, 0, 5, 5);
    applyStimulus("ev11",     0, 1, 0, 0, 3'd0, 1, 3, 1, 6, 1, 5, 5);
    // Reconfigure to 7 with a coincident event
    applyStimulus("load7",    0, 1, 1, 0, 3'd7, 1, 4, 0, 0, 1, 5, 5);
    applyStimulus("l7m1",     0, 1, 0, 0, 3'd0, 1, 5, 0, 0, 0, 7, 1);
    applyStimulus("l7m2",     0, 1, 0, 0, 3'd0, 1, 6, 0, 0, 0, 7, 2);
    applyStimulus("l7m3",     0, 1, 0, 0, 3'd0, 1, 7, 0, 0, 0, 7, 3);
    applyStimulus("l7m4",     0, 1, 0, 0, 3'd0, 1, 0, 0, 0, 0, 7, 4);
    applyStimulus("l7m5",     0, 1, 0, 0, 3'd0, 1, 1, 0, 0, 0, 7, 5);
    applyStimulus("l7m6",     0, 1, 0, 0, 3'd0, 1, 2, 0, 0, 0, 7, 6);
    applyStimulus("l7m7",     0, 1, 0, 0, 3'd0, 1, 3, 1, 4, 0, 7, 7);
    applyStimulus("l7m8",     0, 1, 0, 0, 3'd0, 1, 4, 1, 5, 1, 7, 7);
    // cfg_len=0 clamps to 1
    applyStimulus("load0",    0, 0, 1, 0, 3'd0, 0, 5, 0, 0, 1, 7, 7);
    applyStimulus("l1e0",     0, 1, 0, 0, 3'd0, 1, 5, 0, 0, 0, 1, 0);
    applyStimulus("l1e1",     0, 1, 0, 0, 3'd0, 1, 6, 1, 5, 0, 1, 1);
    applyStimulus("l1e2",     0, 1, 0, 0, 3'd0, 1, 7, 1, 6, 1, 1, 1);
    // cfg_len=1 with coincident event goes straight to RUN
    applyStimulus("load1",    0, 1, 1, 0, 3'd1, 1, 0, 0, 0, 1, 1, 1);
    applyStimulus("l1e3",     0, 1, 0, 0, 3'd0, 1, 1, 1, 0, 0, 1, 1);
    // Flush without event
    applyStimulus("flush",    0, 0, 0, 1, 3'd0, 0, 2, 0, 0, 1, 1, 1);
    applyStimulus("postfl",   0, 0, 0, 0, 3'd0, 0, 2, 0, 0, 0, 1, 0);
    // cfg_load and flush together act as cfg_load
    applyStimulus("ldfl3",    0, 1, 1, 1, 3'd3, 1, 2, 0, 0, 0, 1, 0);
    applyStimulus("l3e1",     0, 1, 0, 0, 3'd0, 1, 3, 0, 0, 0, 3, 1);
    applyStimulus("l3e2",     0, 1, 0, 0, 3'd0, 1, 4, 0, 0, 0, 3, 2);
    applyStimulus("l3e3",     0, 1, 0, 0, 3'd0, 1, 5, 1, 2, 0, 3, 3);
    // Reset while dout_vld is high
    applyStimulus("rstmid",   1, 1, 0, 0, 3'd0, 1, 6, 1, 3, 1, 3, 3);
    applyStimulus("postrst",  0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 5, 0);

    @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
